imm_gen_stage: RTL and testbench

Registered, flow-controlled immediate generator for the decode stage. It accepts one 32-bit instruction per handshake and classifies its format (R/I/S/B/U/J/illegal). It produces the sign-extended immediate at a parametrised datapath width and carries a sideband tag alongside. A two-entry skid buffer decouples the upstream fetch stage from downstream stalls, so `in_ready` never depends combinationally on `out_ready`.

---
 rtl/imm_gen_stage.sv | 193 +++++++++++++++++++
 tb/tb_imm_gen_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: classifies an RV32 instruction word and emits its sign-extended immediate plus tag.
// One cycle of latency; a two-entry skid buffer keeps in_ready registered so it never depends on out_ready.
module imm_gen_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic [TAG_W-1:0] tag;
  } entry_t;

  // Encoding is {output valid, skid valid}; 2'b01 cannot be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("imm_gen_stage: XLEN must be 32 or 64");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("imm_gen_stage: TAG_W must be at least 1");
  end

  logic [6:0]      opcode;
  logic [31:0]     imm32;
  logic [2:0]      dec_fmt;
  logic [XLEN-1:0] imm_ext;
  entry_t          dec_entry;

  assign opcode = in_inst[6:0];

  always_comb begin
    imm32   = '0;
    dec_fmt = FMT_ILL;
    case (opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        dec_fmt = FMT_I;
        imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        imm32   = {in_inst[31:12], 12'b0};
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
      end
      OP_REG: begin
        dec_fmt = FMT_R;
        imm32   = '0;
      end
      default: begin
        dec_fmt = FMT_ILL;
        imm32   = '0;
      end
    endcase
  end

  // Every format is already sign-correct at 32 bits, so widening is a plain bit-31 replication.
  if (XLEN > 32) begin : g_wide
    assign imm_ext = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign imm_ext = imm32[XLEN-1:0];
  end

  always_comb begin
    dec_entry     = '0;
    dec_entry.imm = imm_ext;
    dec_entry.fmt = dec_fmt;
    dec_entry.tag = in_tag;
  end

  state_t state_q;
  state_t state_d;
  entry_t or_q;
  entry_t sk_q;
  logic   acc;
  logic   pop;
  logic   load_or_new;
  logic   load_or_sk;
  logic   load_sk_new;

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (acc) state_d = ST_ONE;
      ST_ONE: begin
        if (acc && !pop) begin
          state_d = ST_FULL;
        end else if (!acc && pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL:  if (pop) state_d = ST_ONE;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_comb begin
    load_or_new = 1'b0;
    load_or_sk  = 1'b0;
    load_sk_new = 1'b0;
    case (state_q)
      ST_EMPTY: load_or_new = acc;
      ST_ONE: begin
        load_or_new = acc & pop;
        load_sk_new = acc & ~pop;
      end
      ST_FULL:  load_or_sk = pop;
      default: ;
    endcase
  end

  // The output register only changes on a pop or when empty, which keeps out_* stable under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      or_q <= '0;
      sk_q <= '0;
    end else begin
      if (load_or_new) begin
        or_q <= dec_entry;
      end else if (load_or_sk) begin
        or_q <= sk_q;
      end
      if (load_sk_new) begin
        sk_q <= dec_entry;
      end
    end
  end

  assign out_imm     = or_q.imm;
  assign out_fmt     = or_q.fmt;
  assign out_tag     = or_q.tag;
  assign out_illegal = (or_q.fmt == FMT_ILL);

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: XLEN=32 and XLEN=64 instances share stimulus and are checked
// against an occupancy/queue reference and an arithmetic immediate model.
module tb_imm_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_tag;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [31:0] out_tag32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [31:0] out_tag64;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_fmt(out_fmt32), .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_fmt(out_fmt64), .out_tag(out_tag64), .out_illegal(out_illegal64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [31:0] tag;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  exp_t        q[$];
  vec_t        tbl[13];
  logic [6:0]  ops[11];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [63:0] nxt_imm;
  logic [2:0]  nxt_fmt;
  bit          last_acc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Immediate computed as a signed offset from the instruction fields.
  function automatic void ref_dec(input logic [31:0] inst, output logic [63:0] imm, output logic [2:0] fmt);
    longint sv;
    longint off;
    sv  = $signed(inst);
    off = 0;
    case (inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        fmt = 3'd1; off = sv >>> 20;
      end
      7'b0100011: begin
        fmt = 3'd2; off = (sv >>> 25) * 32 + longint'(inst[11:7]);
      end
      7'b1100011: begin
        fmt = 3'd3;
        off = (inst[31] ? -4096 : 0) + (inst[7] ? 2048 : 0)
            + longint'(inst[30:25]) * 32 + longint'(inst[11:8]) * 2;
      end
      7'b0110111, 7'b0010111: begin
        fmt = 3'd4; off = (sv >>> 12) * 4096;
      end
      7'b1101111: begin
        fmt = 3'd5;
        off = (inst[31] ? -1048576 : 0) + longint'(inst[19:12]) * 4096
            + (inst[20] ? 2048 : 0) + longint'(inst[30:21]) * 2;
      end
      7'b0110011: begin
        fmt = 3'd0; off = 0;
      end
      default: begin
        fmt = 3'd7; off = 0;
      end
    endcase
    imm = off;
  endfunction

  // One clock: check outputs against the reference at negedge, then advance the reference at posedge.
  task automatic step();
    int cnt;
    bit acc;
    bit pop;
    @(negedge clk);
    cnt = q.size();
    check("out_valid32", out_valid32, cnt > 0);
    check("out_valid64", out_valid64, cnt > 0);
    check("in_ready32", in_ready32, cnt < 2);
    check("in_ready64", in_ready64, cnt < 2);
    if (cnt > 0) begin
      check("out_imm32", out_imm32, q[0].imm[31:0]);
      check("out_imm64", out_imm64, q[0].imm);
      check("out_fmt32", out_fmt32, q[0].fmt);
      check("out_fmt64", out_fmt64, q[0].fmt);
      check("out_tag32", out_tag32, q[0].tag);
      check("out_tag64", out_tag64, q[0].tag);
      check("out_illegal32", out_illegal32, q[0].fmt == 3'd7);
      check("out_illegal64", out_illegal64, q[0].fmt == 3'd7);
    end
    acc = rst_n && in_valid && (cnt < 2);
    pop = rst_n && (cnt > 0) && out_ready;
    last_acc = acc;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{nxt_imm, nxt_fmt, in_tag});
    end
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] tag);
    in_valid = 1'b1;
    in_inst  = inst;
    in_tag   = tag;
    ref_dec(inst, nxt_imm, nxt_fmt);
  endtask

  initial begin
    tbl[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1};
    tbl[1]  = '{32'h00812223, 64'h0000_0000_0000_0004, 3'd2};
    tbl[2]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3};
    tbl[3]  = '{32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4};
    tbl[4]  = '{32'h0040006F, 64'h0000_0000_0000_0004, 3'd5};
    tbl[5]  = '{32'h00000033, 64'h0000_0000_0000_0000, 3'd0};
    tbl[6]  = '{32'h0000007F, 64'h0000_0000_0000_0000, 3'd7};
    tbl[7]  = '{32'h00000013, 64'h0000_0000_0000_0000, 3'd1};
    tbl[8]  = '{32'h7FF00093, 64'h0000_0000_0000_07FF, 3'd1};
    tbl[9]  = '{32'hFFC42283, 64'hFFFF_FFFF_FFFF_FFFC, 3'd1};
    tbl[10] = '{32'h00001017, 64'h0000_0000_0000_1000, 3'd4};
    tbl[11] = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2};
    tbl[12] = '{32'h0000000B, 64'h0000_0000_0000_0000, 3'd7};
    ops = '{7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011, 7'b0100011, 7'b1100011,
            7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1111111};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0; nxt_imm = '0; nxt_fmt = '0; last_acc = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    check("rst_out_valid32", out_valid32, 1'b0);
    check("rst_out_valid64", out_valid64, 1'b0);
    check("rst_in_ready32", in_ready32, 1'b1);
    check("rst_in_ready64", in_ready64, 1'b1);
    check("rst_imm32", out_imm32, 32'd0);
    check("rst_imm64", out_imm64, 64'd0);
    check("rst_fmt32", out_fmt32, 3'd0);
    check("rst_fmt64", out_fmt64, 3'd0);
    check("rst_tag32", out_tag32, 32'd0);
    check("rst_tag64", out_tag64, 32'd0);
    check("rst_illegal32", out_illegal32, 1'b0);
    check("rst_illegal64", out_illegal64, 1'b0);
    rst_n = 1'b1;

    // Table stream at full rate with the sink always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1;
      in_inst  = tbl[i].inst;
      in_tag   = 32'd100 + i;
      nxt_imm  = tbl[i].imm;
      nxt_fmt  = tbl[i].fmt;
      step();
      check("tbl_accept", last_acc, 1'b1);
    end
    in_valid = 1'b0;
    repeat (3) step();

    // Back-pressure: tags 1,2 fill the stage, tag 3 waits until the first pop.
    out_ready = 1'b0;
    offer(32'hFFF00093, 32'd1); step();
    offer(32'h00812223, 32'd2); step();
    offer(32'hFE000EE3, 32'd3);
    repeat (3) step();
    check("bp_tag3_held", q.size(), 2);
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      if (last_acc) in_valid = 1'b0;
    end
    check("bp_drained", q.size(), 0);

    // Reset while full: both entries and the offered one must vanish.
    out_ready = 1'b0;
    offer(32'h0040006F, 32'h55); step();
    offer(32'h800000B7, 32'h66); step();
    step();
    rst_n = 1'b0;
    offer(32'h00000013, 32'h77);
    step();
    rst_n = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    // Random traffic against the reference queue.
    for (int c = 0; c < 10000; c++) begin
      logic [31:0] inst;
      inst = $urandom;
      if ($urandom_range(0, 9) != 0) inst[6:0] = ops[$urandom_range(0, 10)];
      offer(inst, $urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    check("final_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
